seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for a bank of common-anode seven-segment digits with a decimal point per digit. Parametrised successor to the single-digit cathode encoder, adding:
- N-digit anode scanning with a programmable per-digit dwell time;
- inter-digit blanking to suppress ghosting;
- per-digit enable;
- tear-free double-buffered updates applied only at frame boundaries.

Sits between the board-level display register and the FPGA anode/cathode pins.

## Interface
- NUM_DIGITS, 8, digit count; legal 1..16
- DIGIT_CYCLES, 100000, clocks each digit is lit; ≥1
- BLANK_CYCLES, 16, clocks all anodes are off before each digit; ≥0 (0 removes blank phase)
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- value  in  4*NUM_DIGITS  hex nibble per digit; digit i = value[4i+3:4i]; digit 0 rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high
- digit_en  in  NUM_DIGITS  per-digit enable, active-high
- load  in  1  one-cycle strobe; captures value/dp_in/digit_en into the pending buffer
- anode  out  NUM_DIGITS  active-low digit select; at most one bit low
- cathode  out  8  active-low segments; [6:0] = g..a, [7] = DP
- frame_done  out  1  one-cycle pulse at each frame wrap

## Operation
- Segment codes for nibbles 0..F (cathode[6:0]): 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- Two-state FSM per digit slot, digit index idx counting 0..NUM_DIGITS-1:
  - BLANK: anode all 1, cathode 8'hFF. Lasts BLANK_CYCLES clocks, then → SHOW.
  - SHOW: anode[idx]=0, cathode = {~dp, code(nibble)}. Lasts DIGIT_CYCLES clocks.
- End of SHOW:
  - idx < last: idx+1, → BLANK. If BLANK_CYCLES=0, go directly to SHOW of the next digit.
  - idx = last: wrap to 0 and pulse frame_done.
- Frame length: NUM_DIGITS*(BLANK_CYCLES+DIGIT_CYCLES) clocks, constant regardless of enables.
- Disabled digit (active digit_en[idx]=0): slot timing unchanged; anode stays all 1 and cathode 8'hFF during its SHOW.
- Buffering:
  - load sets pending_valid and overwrites the pending registers; the latest load wins.
  - At frame wrap, if pending_valid, pending → active and pending_valid clears.
  - load in the same cycle as the wrap: the load's inputs go straight to active and pending_valid stays 0.
- Display always uses active registers only; mid-frame input changes never reach the pins.

## Timing
- Reset values:
  - anode all 1, cathode 8'hFF, frame_done 0;
  - idx 0, state BLANK (SHOW if BLANK_CYCLES=0), dwell counter 0;
  - active and pending registers 0, pending_valid 0.
- Digits stay dark after reset until the first load has been transferred.
- All outputs are registered. anode/cathode change on the same edge the FSM enters a state, never mid-state.
- First SHOW of digit 0 after reset: anode[0] goes low on edge BLANK_CYCLES+1 after rst deasserts.
- frame_done is high for exactly the cycle in which idx returns to 0.
- Load latency: visible at the first frame wrap at or after the load cycle. Worst case is one frame.
- rst mid-frame: immediate return to reset state on the next edge; pending data is discarded.
- Counter widths: $clog2 of max(DIGIT_CYCLES, BLANK_CYCLES, 2). No wrap or overflow beyond terminal count.

## Configuration
- SEG7_LZ_SUPPRESS_EN defined: leading-zero suppression on the active value.
  - Digit i is suppressed when its nibble and every higher enabled digit's nibble are 0.
  - Digit 0 is never suppressed.
  - A suppressed digit shows cathode[6:0]=7'h7F, but its DP is still driven from dp_in.
  - Slot timing is unchanged.
- Undefined: every enabled digit shows its nibble, including leading zeros. No suppression logic is generated.

## Structure
- Package seg7_pkg holds:
  - the 16-entry segment code constant array;
  - the FSM state enum {BLANK, SHOW};
  - the cathode blank constant 8'hFF.
- Sub-module seg7_encode: combinational nibble + dp → 8-bit active-low cathode, instantiated once on the idx-selected nibble.

## Test plan
Bench parameters: NUM_DIGITS=4, DIGIT_CYCLES=4, BLANK_CYCLES=2 (24-clock frame).
- Reset, then no load → anode stays 4'hF and cathode 8'hFF for 3 full frames; frame_done pulses every 24 clocks.
- load value=16'h12AF, dp_in=4'b0100, digit_en=4'hF → next frame:
  - anode 1110/F, cathode 8'h8E;
  - anode 1101/A, cathode 8'h88;
  - anode 1011/2, cathode 8'h24 (DP on);
  - anode 0111/1, cathode 8'hF9.
- Two loads mid-frame (16'h1111, then 16'h2222) → current frame unchanged; next frame shows 2222 only.
- load coincident with the frame_done cycle → the new value appears in that new frame's digit 0 slot.
- digit_en=4'b1010 → digit slots 0 and 2 are dark for their full 4 cycles; frame still 24 clocks.
- With SEG7_LZ_SUPPRESS_EN, value=16'h0000 → digits 3..1 show cathode 8'hFF and digit 0 shows 8'hC0.
- rst asserted mid-frame → outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan driver: segment code table,
// scan FSM states, the all-off cathode pattern and a dwell-counter width helper.
package seg7_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [7:0] CATHODE_BLANK = 8'hFF;

  // Active-low segments g..a for hex nibbles 0..F.
  localparam logic [6:0] SEG_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Width holding max(a, b, 2) - 1, the largest value the down-counter loads.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display bus: frame data and load strobe in, anode/cathode pins and frame pulse out.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load;
  logic [NUM_DIGITS-1:0]   anode;
  logic [7:0]              cathode;
  logic                    frame_done;

  modport master (
    output value, dp_in, digit_en, load,
    input  anode, cathode, frame_done
  );

  modport slave (
    input  value, dp_in, digit_en, load,
    output anode, cathode, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver_encode.sv
// Nibble plus decimal point to active-low cathode pattern {~dp, g..a}.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] cathode
);

  assign cathode = {~dp, SEG_CODE[nibble]};

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit common-anode scan driver with inter-digit blanking, per-digit enable
// and double-buffered frame data swapped only at the frame wrap.
// Optional build macro: SEG7_LZ_SUPPRESS_EN (leading-zero suppression).
//
//   state | meaning
//   ------+------------------------------------------------------------
//   BLANK | all anodes off, cathode all off, for BLANK_CYCLES clocks
//   SHOW  | anode[idx] on (if enabled), segments of digit idx, DIGIT_CYCLES clocks
//
// The cycle after reset re-enters the reset state so its dwell is timed from
// the first edge that sees rst low.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   bus
);

  localparam int              CW         = cnt_width(DIGIT_CYCLES, BLANK_CYCLES);
  localparam int              IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0]   LAST       = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0]   SHOW_LOAD  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0]   BLANK_LOAD = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam state_t          RST_STATE  = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    run, enter, wrap;

  logic [4*NUM_DIGITS-1:0] act_value, act_value_nxt, pend_value, pend_value_nxt;
  logic [NUM_DIGITS-1:0]   act_dp, act_dp_nxt, pend_dp, pend_dp_nxt;
  logic [NUM_DIGITS-1:0]   act_en, act_en_nxt, pend_en, pend_en_nxt;
  logic                    pend_valid, pend_valid_nxt;

  logic [3:0]              nib_sel;
  logic                    dp_sel, en_sel, sup_sel;
  logic [7:0]              enc_cathode, cathode_nxt, cathode_q;
  logic [NUM_DIGITS-1:0]   anode_nxt, anode_q;
  logic                    frame_done_q;

  // Next state, slot index and dwell reload; enter marks every state entry.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    enter     = 1'b0;
    wrap      = 1'b0;
    if (!run) begin
      enter = 1'b1;
    end else if (cnt != '0) begin
      cnt_nxt = cnt - 1'b1;
    end else begin
      enter = 1'b1;
      if (state == BLANK) begin
        state_nxt = SHOW;
      end else begin
        if (idx == LAST) begin
          idx_nxt = '0;
          wrap    = 1'b1;
        end else begin
          idx_nxt = idx + 1'b1;
        end
        state_nxt = (BLANK_CYCLES == 0) ? SHOW : BLANK;
      end
    end
    if (enter) cnt_nxt = (state_nxt == BLANK) ? BLANK_LOAD : SHOW_LOAD;
  end

  // Scan state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_STATE;
      idx   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      run   <= 1'b1;
    end
  end

  // Pending/active buffers; a load coinciding with the wrap bypasses pending.
  always_comb begin
    act_value_nxt  = act_value;
    act_dp_nxt     = act_dp;
    act_en_nxt     = act_en;
    pend_value_nxt = pend_value;
    pend_dp_nxt    = pend_dp;
    pend_en_nxt    = pend_en;
    pend_valid_nxt = pend_valid;
    if (bus.load) begin
      pend_value_nxt = bus.value;
      pend_dp_nxt    = bus.dp_in;
      pend_en_nxt    = bus.digit_en;
      pend_valid_nxt = 1'b1;
    end
    if (wrap) begin
      if (bus.load) begin
        act_value_nxt = bus.value;
        act_dp_nxt    = bus.dp_in;
        act_en_nxt    = bus.digit_en;
      end else if (pend_valid) begin
        act_value_nxt = pend_value;
        act_dp_nxt    = pend_dp;
        act_en_nxt    = pend_en;
      end
      pend_valid_nxt = 1'b0;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_value  <= '0;
      act_dp     <= '0;
      act_en     <= '0;
      pend_value <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
      pend_valid <= 1'b0;
    end else begin
      act_value  <= act_value_nxt;
      act_dp     <= act_dp_nxt;
      act_en     <= act_en_nxt;
      pend_value <= pend_value_nxt;
      pend_dp    <= pend_dp_nxt;
      pend_en    <= pend_en_nxt;
      pend_valid <= pend_valid_nxt;
    end
  end

  // Select the digit being entered, from the buffer contents it will see.
  always_comb begin
    nib_sel = act_value_nxt[{idx_nxt, 2'b00} +: 4];
    dp_sel  = act_dp_nxt[idx_nxt];
    en_sel  = act_en_nxt[idx_nxt];
  end

  seg7_encode u_encode (
    .nibble  (nib_sel),
    .dp      (dp_sel),
    .cathode (enc_cathode)
  );

`ifdef SEG7_LZ_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] lz_sup;

  // A digit is a leading zero while it and every enabled digit above it are 0.
  always_comb begin
    logic zero_above;
    lz_sup     = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (act_en_nxt[i]) begin
        lz_sup[i]  = zero_above && (act_value_nxt[4*i +: 4] == 4'h0);
        zero_above = lz_sup[i];
      end
    end
  end

  assign sup_sel = lz_sup[idx_nxt];
`else
  assign sup_sel = 1'b0;
`endif

  // Pin pattern for the state being entered.
  always_comb begin
    anode_nxt   = '1;
    cathode_nxt = CATHODE_BLANK;
    if (state_nxt == SHOW && en_sel) begin
      anode_nxt[idx_nxt] = 1'b0;
      cathode_nxt        = enc_cathode;
      if (sup_sel) cathode_nxt[6:0] = 7'h7F;
    end
  end

  // Output registers; pins only move on a state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      anode_q      <= '1;
      cathode_q    <= CATHODE_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= wrap;
      if (enter) begin
        anode_q   <= anode_nxt;
        cathode_q <= cathode_nxt;
      end
    end
  end

  assign bus.anode      = anode_q;
  assign bus.cathode    = cathode_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: 4 digits, 4-clock dwell, 2-clock blank (24-clock frame).
// Expected pins come from a frame-position model fed by the loads seen on the bus.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int DC    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = DC + BC;
  localparam int FRAME = ND * SLOT;

  localparam logic [6:0] CODES [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: m_k counts edges since reset released; the displayed data
  // changes only at edges where a new frame begins.
  int          m_k;
  logic [15:0] m_act_val, m_pend_val;
  logic [3:0]  m_act_dp, m_act_en, m_pend_dp, m_pend_en;
  logic        m_pv;

  always @(posedge clk) begin
    if (rst) begin
      m_k        <= 0;
      m_act_val  <= '0; m_act_dp  <= '0; m_act_en  <= '0;
      m_pend_val <= '0; m_pend_dp <= '0; m_pend_en <= '0;
      m_pv       <= 1'b0;
    end else begin
      m_k <= m_k + 1;
      if (bus.load) begin
        m_pend_val <= bus.value; m_pend_dp <= bus.dp_in; m_pend_en <= bus.digit_en;
      end
      if (m_k > 0 && m_k % FRAME == 0) begin
        if (bus.load) begin
          m_act_val <= bus.value; m_act_dp <= bus.dp_in; m_act_en <= bus.digit_en;
        end else if (m_pv) begin
          m_act_val <= m_pend_val; m_act_dp <= m_pend_dp; m_act_en <= m_pend_en;
        end
        m_pv <= 1'b0;
      end else if (bus.load) begin
        m_pv <= 1'b1;
      end
    end
  end

`ifdef SEG7_LZ_SUPPRESS_EN
  function automatic logic lz_suppressed(input int slot);
    if (m_act_val[slot*4 +: 4] != 4'h0) return 1'b0;
    for (int j = ND - 1; j > slot; j--)
      if (m_act_en[j] && m_act_val[j*4 +: 4] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction
`endif

  // {anode, cathode, frame_done} expected after the most recent edge.
  function automatic logic [12:0] model_out();
    logic [3:0] an;
    logic [7:0] ca;
    logic       fd;
    logic [3:0] nib;
    int         p, slot;
    an = 4'hF; ca = 8'hFF; fd = 1'b0;
    if (m_k > 0) begin
      p    = (m_k - 1) % FRAME;
      slot = p / SLOT;
      fd   = (m_k > 1) && (p == 0);
      if ((p % SLOT) >= BC && m_act_en[slot]) begin
        an[slot] = 1'b0;
        nib      = m_act_val[slot*4 +: 4];
        ca       = {~m_act_dp[slot], CODES[nib]};
`ifdef SEG7_LZ_SUPPRESS_EN
        if (slot != 0 && lz_suppressed(slot)) ca[6:0] = 7'h7F;
`endif
      end
    end
    return {an, ca, fd};
  endfunction

  logic [12:0] want;

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.anode, bus.cathode, bus.frame_done} !== {4'hF, 8'hFF, 1'b0}) begin
        errors++;
        $display("FAIL reset: anode=%h cathode=%h fd=%b required F/FF/0", bus.anode, bus.cathode, bus.frame_done);
      end
    end
    bus.value = '0; bus.dp_in = '0; bus.digit_en = '0; bus.load = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_no_load();
    int pulses = 0;
    for (int i = 0; i < 3 * FRAME + 1; i++) begin
      @(negedge clk);
      want = model_out(); checks++;
      if ({bus.anode, bus.cathode, bus.frame_done} !== want) begin
        errors++;
        $display("FAIL idle k=%0d: got %h/%h/%b required %h/%h/%b", m_k, bus.anode, bus.cathode, bus.frame_done, want[12:9], want[8:1], want[0]);
      end
      if (bus.frame_done) pulses++;
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL idle_pulses: got %0d required 3", pulses);
    end
  endtask

  task automatic test_directed();
    logic [3:0] exp_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] exp_ca [4] = '{8'h8E, 8'h88, 8'h24, 8'hF9};
    logic got_wrap = 1'b0;
    bus.value = 16'h12AF; bus.dp_in = 4'b0100; bus.digit_en = 4'hF; bus.load = 1'b1;
    for (int i = 0; i < 2 * FRAME && !got_wrap; i++) begin
      @(negedge clk);
      want = model_out(); checks++;
      if ({bus.anode, bus.cathode, bus.frame_done} !== want) begin
        errors++;
        $display("FAIL directed_wait k=%0d: got %h/%h/%b required %h/%h/%b", m_k, bus.anode, bus.cathode, bus.frame_done, want[12:9], want[8:1], want[0]);
      end
      bus.load = 1'b0;
      if (bus.frame_done) got_wrap = 1'b1;
    end
    checks++;
    if (!got_wrap) begin errors++; $display("FAIL directed_timeout: no frame_done got 0 required 1"); end
    for (int c = 1; c < FRAME; c++) begin
      @(negedge clk);
      want = model_out(); checks++;
      if ({bus.anode, bus.cathode, bus.frame_done} !== want) begin
        errors++;
        $display("FAIL directed k=%0d: got %h/%h/%b required %h/%h/%b", m_k, bus.anode, bus.cathode, bus.frame_done, want[12:9], want[8:1], want[0]);
      end
      if (c % SLOT == BC) begin
        checks++;
        if ({bus.anode, bus.cathode} !== {exp_an[c/SLOT], exp_ca[c/SLOT]}) begin
          errors++;
          $display("FAIL directed_digit%0d: got %h/%h required %h/%h", c/SLOT, bus.anode, bus.cathode, exp_an[c/SLOT], exp_ca[c/SLOT]);
        end
      end
    end
  endtask

  task automatic test_two_loads();
    logic got_wrap = 1'b0;
    for (int i = 0; i < 2 * FRAME && !got_wrap; i++) begin
      @(negedge clk);
      if (bus.frame_done) got_wrap = 1'b1;
    end
    checks++;
    if (!got_wrap) begin errors++; $display("FAIL two_loads_timeout: no frame_done got 0 required 1"); end
    for (int c = 1; c < 2 * FRAME; c++) begin
      @(negedge clk);
      want = model_out(); checks++;
      if ({bus.anode, bus.cathode, bus.frame_done} !== want) begin
        errors++;
        $display("FAIL two_loads k=%0d: got %h/%h/%b required %h/%h/%b", m_k, bus.anode, bus.cathode, bus.frame_done, want[12:9], want[8:1], want[0]);
      end
      if (c == 3 * SLOT + BC) begin
        checks++;
        if ({bus.anode, bus.cathode} !== {4'h7, 8'hF9}) begin
          errors++;
          $display("FAIL two_loads_old_frame: got %h/%h required 7/F9", bus.anode, bus.cathode);
        end
      end
      if (c == FRAME + BC || c == FRAME + 3 * SLOT + BC) begin
        checks++;
        if ({bus.anode, bus.cathode} !== {((c == FRAME + BC) ? 4'hE : 4'h7), 8'hA4}) begin
          errors++;
          $display("FAIL two_loads_new_frame c=%0d: got %h/%h required %s/A4", c, bus.anode, bus.cathode, (c == FRAME + BC) ? "E" : "7");
        end
      end
      bus.load     = (c == 5) || (c == 9);
      bus.value    = (c == 5) ? 16'h1111 : 16'h2222;
      bus.dp_in    = 4'b0000;
      bus.digit_en = 4'hF;
    end
  endtask

  // Entered on the negedge just before a wrap edge.
  task automatic test_load_at_wrap();
    logic [15:0] v  = 16'($urandom);
    logic [3:0]  dp = 4'($urandom);
    bus.value = v; bus.dp_in = dp; bus.digit_en = 4'hF; bus.load = 1'b1;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      want = model_out(); checks++;
      if ({bus.anode, bus.cathode, bus.frame_done} !== want) begin
        errors++;
        $display("FAIL load_at_wrap k=%0d: got %h/%h/%b required %h/%h/%b", m_k, bus.anode, bus.cathode, bus.frame_done, want[12:9], want[8:1], want[0]);
      end
      bus.load = 1'b0;
      if (c == 0) begin
        checks++;
        if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL load_at_wrap_pulse: got %b required 1", bus.frame_done); end
      end
      if (c == BC) begin
        checks++;
        if ({bus.anode, bus.cathode} !== {4'hE, ~dp[0], CODES[v[3:0]]}) begin
          errors++;
          $display("FAIL load_at_wrap_digit0: got %h/%h required E/%h", bus.anode, bus.cathode, {~dp[0], CODES[v[3:0]]});
        end
      end
    end
  endtask

  task automatic test_digit_en();
    logic got_wrap = 1'b0;
    bus.value = 16'($urandom); bus.dp_in = 4'($urandom); bus.digit_en = 4'b1010; bus.load = 1'b1;
    for (int i = 0; i < 2 * FRAME && !got_wrap; i++) begin
      @(negedge clk);
      bus.load = 1'b0;
      if (bus.frame_done) got_wrap = 1'b1;
    end
    checks++;
    if (!got_wrap) begin errors++; $display("FAIL digit_en_timeout: no frame_done got 0 required 1"); end
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      want = model_out(); checks++;
      if ({bus.anode, bus.cathode, bus.frame_done} !== want) begin
        errors++;
        $display("FAIL digit_en k=%0d: got %h/%h/%b required %h/%h/%b", m_k, bus.anode, bus.cathode, bus.frame_done, want[12:9], want[8:1], want[0]);
      end
      if (c < SLOT || (c >= 2 * SLOT && c < 3 * SLOT)) begin
        checks++;
        if ({bus.anode, bus.cathode} !== {4'hF, 8'hFF}) begin
          errors++;
          $display("FAIL digit_en_dark c=%0d: got %h/%h required F/FF", c, bus.anode, bus.cathode);
        end
      end
      if (c == FRAME) begin
        checks++;
        if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL digit_en_frame_len: frame_done got %b required 1", bus.frame_done); end
      end
    end
  endtask

  task automatic test_zero();
    logic got_wrap = 1'b0;
    logic [7:0] exp_ca;
    bus.value = 16'h0000; bus.dp_in = 4'b0000; bus.digit_en = 4'hF; bus.load = 1'b1;
    for (int i = 0; i < 2 * FRAME && !got_wrap; i++) begin
      @(negedge clk);
      bus.load = 1'b0;
      if (bus.frame_done) got_wrap = 1'b1;
    end
    checks++;
    if (!got_wrap) begin errors++; $display("FAIL zero_timeout: no frame_done got 0 required 1"); end
    for (int c = 1; c < FRAME; c++) begin
      @(negedge clk);
      want = model_out(); checks++;
      if ({bus.anode, bus.cathode, bus.frame_done} !== want) begin
        errors++;
        $display("FAIL zero k=%0d: got %h/%h/%b required %h/%h/%b", m_k, bus.anode, bus.cathode, bus.frame_done, want[12:9], want[8:1], want[0]);
      end
      if (c % SLOT == BC) begin
`ifdef SEG7_LZ_SUPPRESS_EN
        exp_ca = (c / SLOT == 0) ? 8'hC0 : 8'hFF;
`else
        exp_ca = 8'hC0;
`endif
        checks++;
        if ({bus.anode, bus.cathode} !== {~(4'b0001 << (c / SLOT)), exp_ca}) begin
          errors++;
          $display("FAIL zero_digit%0d: got %h/%h required %h/%h", c / SLOT, bus.anode, bus.cathode, ~(4'b0001 << (c / SLOT)), exp_ca);
        end
      end
    end
  endtask

  task automatic test_random();
    int gap;
    for (int n = 0; n < 10; n++) begin
      gap = $urandom_range(0, 30);
      bus.value = 16'($urandom); bus.dp_in = 4'($urandom); bus.digit_en = 4'($urandom);
      for (int i = 0; i <= gap; i++) begin
        bus.load = (i == gap);
        @(negedge clk);
        want = model_out(); checks++;
        if ({bus.anode, bus.cathode, bus.frame_done} !== want) begin
          errors++;
          $display("FAIL random k=%0d: got %h/%h/%b required %h/%h/%b", m_k, bus.anode, bus.cathode, bus.frame_done, want[12:9], want[8:1], want[0]);
        end
      end
      bus.load = 1'b0;
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      want = model_out(); checks++;
      if ({bus.anode, bus.cathode, bus.frame_done} !== want) begin
        errors++;
        $display("FAIL random_tail k=%0d: got %h/%h/%b required %h/%h/%b", m_k, bus.anode, bus.cathode, bus.frame_done, want[12:9], want[8:1], want[0]);
      end
    end
  endtask

  task automatic test_rst_mid();
    logic got_wrap = 1'b0;
    int   lit = 0;
    bus.value = 16'h5A3C; bus.dp_in = 4'b1111; bus.digit_en = 4'hF; bus.load = 1'b1;
    for (int i = 0; i < 2 * FRAME && !got_wrap; i++) begin
      @(negedge clk);
      bus.load = 1'b0;
      if (bus.frame_done) got_wrap = 1'b1;
    end
    checks++;
    if (!got_wrap) begin errors++; $display("FAIL rst_mid_timeout: no frame_done got 0 required 1"); end
    for (int c = 1; c <= SLOT + BC + 1; c++) begin
      @(negedge clk);
      bus.load  = (c == SLOT + BC);
      bus.value = 16'h9999;
    end
    bus.load = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.anode, bus.cathode, bus.frame_done} !== {4'hF, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid: got %h/%h/%b required F/FF/0", bus.anode, bus.cathode, bus.frame_done);
    end
    rst = 1'b0;
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      @(negedge clk);
      want = model_out(); checks++;
      if ({bus.anode, bus.cathode, bus.frame_done} !== want) begin
        errors++;
        $display("FAIL rst_mid_after k=%0d: got %h/%h/%b required %h/%h/%b", m_k, bus.anode, bus.cathode, bus.frame_done, want[12:9], want[8:1], want[0]);
      end
      if (bus.anode !== 4'hF) lit++;
    end
    checks++;
    if (lit != 0) begin errors++; $display("FAIL rst_mid_pending_discarded: lit cycles got %0d required 0", lit); end
  endtask

  initial begin
    bus.value = '0; bus.dp_in = '0; bus.digit_en = '0; bus.load = 1'b0;
    test_reset();
    test_no_load();
    test_directed();
    test_two_loads();
    test_load_at_wrap();
    test_digit_en();
    test_zero();
    test_random();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
